// File: rtl/regfile_pkg.sv
// Shared types and constants for the register file read stage.
// Bypass of same-cycle writes is enabled by defining REGFILE_READ_BYPASS_EN.
package regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int XLEN     = 64;
    localparam int TAG_W    = 6;

    typedef logic [4:0]      reg_idx_t;
    typedef logic [XLEN-1:0] word_t;

    localparam reg_idx_t ZERO_REG = 5'd31;

    typedef struct packed {
        word_t            a;
        word_t            b;
        logic [TAG_W-1:0] tag;
    } read_entry_t;

endpackage

// File: rtl/regfile_operand_select.sv
// Resolves one operand: zero register, optional write bypass, else array read.
// Write forwarding is compiled in with REGFILE_READ_BYPASS_EN.
module regfile_operand_select
    import regfile_pkg::*;
(
    input  logic [4:0]        idx,
    input  logic [31:0][63:0] regs,
    input  logic [31:0]       wr_en,
    input  logic [63:0]       wr_data,
    output logic [63:0]       data
);

`ifdef REGFILE_READ_BYPASS_EN
    always_comb begin
        data = regs[idx];
        if (idx == ZERO_REG)
            data = '0;
        else if (wr_en[idx])
            data = wr_data;
    end
`else
    // write port is ignored; readers see the pre-write value
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_data};

    always_comb begin
        data = regs[idx];
        if (idx == ZERO_REG)
            data = '0;
    end
`endif

endmodule

// File: rtl/regfile_read_stage.sv
// Two-operand register read with a 2-entry snapshot output buffer.
// Same-cycle write forwarding is enabled by REGFILE_READ_BYPASS_EN.
module regfile_read_stage
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0][63:0] regs,
    input  logic [31:0]       wr_en,
    input  logic [63:0]       wr_data,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_ra,
    input  logic [4:0]        req_rb,
    input  logic [5:0]        req_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       rsp_a,
    output logic [63:0]       rsp_b,
    output logic [5:0]        rsp_tag
);

    read_entry_t mem [2];
    logic [1:0]  count;
    logic        wptr;
    logic        rptr;
    word_t       op_a;
    word_t       op_b;
    logic        push;
    logic        pop;

    regfile_operand_select u_sel_a (
        .idx     (req_ra),
        .regs    (regs),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .data    (op_a)
    );

    regfile_operand_select u_sel_b (
        .idx     (req_rb),
        .regs    (regs),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .data    (op_b)
    );

    // ready is a pure function of occupancy: no path from rsp_ready
    assign req_ready = (count < 2'd2);
    assign rsp_valid = (count != 2'd0);
    assign push      = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    assign rsp_a   = mem[rptr].a;
    assign rsp_b   = mem[rptr].b;
    assign rsp_tag = mem[rptr].tag;

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= '{a: op_a, b: op_b, tag: req_tag};
                wptr      <= ~wptr;
            end
            if (pop)
                rptr <= ~rptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_read_stage.sv
// Directed test for regfile_read_stage; expectations follow REGFILE_READ_BYPASS_EN.
module tb_regfile_read_stage;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0][63:0] regs;
    logic [31:0]       wr_en;
    logic [63:0]       wr_data;
    logic              req_valid;
    logic              req_ready;
    logic [4:0]        req_ra;
    logic [4:0]        req_rb;
    logic [5:0]        req_tag;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [63:0]       rsp_a;
    logic [63:0]       rsp_b;
    logic [5:0]        rsp_tag;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_read_stage dut (
        .clk       (clk),
        .reset     (reset),
        .regs      (regs),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ra    (req_ra),
        .req_rb    (req_rb),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_a     (rsp_a),
        .rsp_b     (rsp_b),
        .rsp_tag   (rsp_tag)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [4:0] ra, input logic [4:0] rb,
                       input logic [5:0] tg);
        req_valid = 1'b1;
        req_ra    = ra;
        req_rb    = rb;
        req_tag   = tg;
    endtask

    initial begin
        reset     = 1'b1;
        regs      = '0;
        wr_en     = '0;
        wr_data   = '0;
        req_valid = 1'b0;
        req_ra    = '0;
        req_rb    = '0;
        req_tag   = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_a", rsp_a, 64'd0);
        check("rst_b", rsp_b, 64'd0);
        check("rst_tag", 64'(rsp_tag), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd1);

        // basic read with zero register on B
        regs[3] = 64'h1F;
        req(5'd3, 5'd31, 6'd5);
        tick();
        req_valid = 1'b0;
        check("t1_valid", 64'(rsp_valid), 64'd1);
        check("t1_a", rsp_a, 64'h1F);
        check("t1_b", rsp_b, 64'd0);
        check("t1_tag", 64'(rsp_tag), 64'd5);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("t1_empty", 64'(rsp_valid), 64'd0);

        // same-cycle write to the read register
        regs[7] = 64'h11;
        wr_en   = 32'h80;
        wr_data = 64'hAB;
        req(5'd7, 5'd3, 6'd6);
        tick();
        req_valid = 1'b0;
        wr_en     = '0;
`ifdef REGFILE_READ_BYPASS_EN
        check("t2_a", rsp_a, 64'hAB);
`else
        check("t2_a", rsp_a, 64'h11);
`endif
        check("t2_b", rsp_b, 64'h1F);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // zero register ignores contents and write enable
        regs[31] = 64'hFFFF;
        wr_en    = 32'h8000_0000;
        wr_data  = 64'h55;
        req(5'd31, 5'd3, 6'd7);
        tick();
        req_valid = 1'b0;
        wr_en     = '0;
        check("t3_a", rsp_a, 64'd0);
        check("t3_b", rsp_b, 64'h1F);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // backpressure: fill, stall, drain in order
        regs[1] = 64'h100;
        regs[2] = 64'h200;
        req(5'd1, 5'd2, 6'd1);
        tick();
        req(5'd2, 5'd1, 6'd2);
        check("t4_rdy1", 64'(req_ready), 64'd1);
        tick();
        req(5'd1, 5'd1, 6'd3);
        check("t4_full", 64'(req_ready), 64'd0);
        check("t4_h1_tag", 64'(rsp_tag), 64'd1);
        check("t4_h1_a", rsp_a, 64'h100);
        tick();
        check("t4_stall_tag", 64'(rsp_tag), 64'd1);
        check("t4_stall_b", rsp_b, 64'h200);
        check("t4_stall_rdy", 64'(req_ready), 64'd0);
        rsp_ready = 1'b1;
        tick();
        check("t4_h2_tag", 64'(rsp_tag), 64'd2);
        check("t4_h2_a", rsp_a, 64'h200);
        check("t4_rdy2", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        check("t4_h3_tag", 64'(rsp_tag), 64'd3);
        check("t4_h3_valid", 64'(rsp_valid), 64'd1);
        tick();
        rsp_ready = 1'b0;
        check("t4_drained", 64'(rsp_valid), 64'd0);

        // snapshot is not disturbed by later writes
        regs[4] = 64'h44;
        req(5'd4, 5'd4, 6'd1);
        tick();
        req_valid = 1'b0;
        regs[4]   = 64'h99;
        wr_en     = 32'h10;
        wr_data   = 64'h77;
        tick();
        wr_en = '0;
        check("t5_a", rsp_a, 64'h44);
        rsp_ready = 1'b1;
        #1;
        check("t5_pop_a", rsp_a, 64'h44);
        tick();
        rsp_ready = 1'b0;
        check("t5_empty", 64'(rsp_valid), 64'd0);

        // reset discards buffered entries
        req(5'd1, 5'd2, 6'd8);
        tick();
        req(5'd2, 5'd1, 6'd9);
        tick();
        req_valid = 1'b0;
        check("t6_full", 64'(req_ready), 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_valid", 64'(rsp_valid), 64'd0);
        check("t6_a", rsp_a, 64'd0);
        check("t6_b", rsp_b, 64'd0);
        check("t6_tag", 64'(rsp_tag), 64'd0);
        check("t6_ready", 64'(req_ready), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_read_stage.md
# regfile_read_stage

Read-side counterpart of the 32x64 architectural register file: accepts two-operand read requests over a valid/ready handshake, selects both 64-bit operands from the register array, and delivers them one cycle later through a 2-entry output buffer that absorbs issue-stage backpressure. It sits between the issue/dispatch logic and the execute stage of the out-of-order pipeline. It also watches the register file's write port, so a write landing in the acceptance cycle can be forwarded.

## Interface
- NUM_REGS, 32, architectural registers; index 31 is the zero register.
- XLEN, 64, data width.
- TAG_W, 6, width of the opaque request tag.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- regs  in  [31:0][63:0]  current register file contents (write-side `dataOut`).
- wr_en  in  32  register file write enables, one-hot or zero.
- wr_data  in  64  register file write data.
- req_valid  in  1  read request present.
- req_ready  out  1  stage can accept a request this cycle.
- req_ra  in  5  operand A register index.
- req_rb  in  5  operand B register index.
- req_tag  in  TAG_W  tag returned with the response.
- rsp_valid  out  1  response at buffer head.
- rsp_ready  in  1  consumer takes the response.
- rsp_a  out  64  operand A.
- rsp_b  out  64  operand B.
- rsp_tag  out  TAG_W  tag of the head response.

## Operation
- Request accepted when req_valid && req_ready. Response popped when rsp_valid && rsp_ready.
- On acceptance, each operand is resolved combinationally and written with req_tag into the 2-entry FIFO.
- Operand resolution for index r:
  - r == 31: result is 64'h0. This applies regardless of regs[31] or wr_en[31].
  - With bypass compiled in and wr_en[r] == 1: result is wr_data.
  - Otherwise: result is regs[r].
- Buffered entries are snapshots. Writes after acceptance never modify them.
- Multi-hot wr_en is illegal input. If it occurs, the behaviour is fixed: only wr_en[r] for the selected index is consulted.
- req_ready = (count < 2). It depends only on state, never on rsp_ready, so there is no combinational ready path.
- rsp_valid = (count > 0). rsp_a, rsp_b and rsp_tag show the head entry. They are held stable while rsp_valid && !rsp_ready.
- Simultaneous push and pop:
  - count is unchanged.
  - The head advances, and the new entry goes behind it (or becomes head if count was 1).
- Reset:
  - count = 0, read and write pointers = 0.
  - rsp_valid = 0, rsp_a = 0, rsp_b = 0, rsp_tag = 0 (storage cleared).
  - req_ready = 1 in the first cycle after reset.
- Reset mid-operation discards all buffered entries. No response is produced for them.

## Timing
- Latency: a request accepted in cycle N appears at the head in cycle N+1 if the buffer was empty at N, or after the preceding entry pops otherwise.
- Throughput: one request per cycle sustained while rsp_ready is held at 1.
- Full (count == 2): req_ready = 0 for that cycle, even if rsp_ready = 1. Ready reasserts the cycle after a pop.
- Empty: rsp_valid = 0. Output data holds its last value and is don't-care.
- FIFO pointers are 1 bit each and wrap modulo 2.

## Configuration
- Macro: REGFILE_READ_BYPASS_EN.
- Defined: a same-cycle write to the selected register (wr_en[r] with r != 31) forwards wr_data into the captured operand.
- Undefined: the operand is always regs[r], the pre-write value. The issue logic must then delay dependent reads by one cycle. wr_en and wr_data are ignored.

## Structure
- Shared package regfile_pkg:
  - constants NUM_REGS = 32, XLEN = 64, ZERO_REG = 5'd31;
  - typedefs reg_idx_t (logic [4:0]) and word_t (logic [63:0]);
  - struct read_entry_t {word_t a; word_t b; logic [TAG_W-1:0] tag}.
- One sub-module, regfile_operand_select. It takes the index, regs, wr_en and wr_data and returns word_t, covering zero-register handling and the bypass. It is instantiated twice, once for A and once for B.

## Test plan
- Reset, then regs[3] = 64'h1F, ra = 3, rb = 31, tag = 5 accepted at N -> at N+1 rsp_valid = 1, rsp_a = 64'h1F, rsp_b = 0, rsp_tag = 5.
- Request ra = 7 with wr_en = 32'h80, wr_data = 64'hAB in the same cycle, regs[7] = 64'h11 -> rsp_a = 64'hAB with bypass compiled in, 64'h11 without.
- ra = 31 with regs[31] = 64'hFFFF and wr_en[31] = 1 -> rsp_a = 0.
- rsp_ready = 0 and three back-to-back requests (tags 1, 2, 3) -> tags 1 and 2 accepted, req_ready = 0 while tag 3 is presented. Raise rsp_ready -> responses in order 1, 2, 3, with data stable while stalled.
- Buffer holding tag 1, write regs[ra] to a new value -> popped rsp_a keeps the captured value.
- Two entries buffered, assert reset for one cycle -> next cycle rsp_valid = 0, rsp_a/b/tag = 0, req_ready = 1.
